// File: rtl/bus_handshake_ctrl.sv
// Registered CPU-to-peripheral bus controller: decodes the top address nibble to
// one of NSLV slaves, waits for its ack (or a timeout) and returns a one-cycle ready.
module bus_handshake_ctrl #(
  parameter int          NSLV     = 16,
  parameter int          TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_ready,
  output logic                 cpu_err,
  output logic [NSLV-1:0]      slv_sel,
  output logic                 slv_we,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_wdata,
  input  logic [32*NSLV-1:0]   slv_rdata,
  input  logic [NSLV-1:0]      slv_ack,
  output logic [7:0]           err_count,
  output logic [31:0]          err_addr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam int             CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [4:0]     NSLV_L    = 5'(NSLV);
  localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [NSLV-1:0]    slv_sel_q, slv_sel_d;
  logic               slv_we_q, slv_we_d;
  logic [31:0]        slv_addr_q, slv_addr_d;
  logic [31:0]        slv_wdata_q, slv_wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic               cpu_ready_q, cpu_ready_d;
  logic               cpu_err_q, cpu_err_d;
  logic [7:0]         err_count_q, err_count_d;
  logic [31:0]        err_addr_q, err_addr_d;

  logic [3:0]  req_idx;
  logic        req_mapped;
  logic        sel_ack;
  logic        timed_out;
  logic [7:0]  err_count_inc;
  logic [31:0] sel_rdata;

  assign req_idx       = cpu_addr[31:28];
  assign req_mapped    = {1'b0, req_idx} < NSLV_L;
  // Only the selected channel's ack counts; stray acks elsewhere are masked off.
  assign sel_ack       = |(slv_ack & slv_sel_q);
  assign timed_out     = (cnt_q == TIMEOUT_L);
  assign err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (slv_sel_q[i]) sel_rdata = slv_rdata[32*i +: 32];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slv_sel_q   <= '0;
      slv_we_q    <= 1'b0;
      slv_addr_q  <= '0;
      slv_wdata_q <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      slv_sel_q   <= slv_sel_d;
      slv_we_q    <= slv_we_d;
      slv_addr_q  <= slv_addr_d;
      slv_wdata_q <= slv_wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_err_q   <= cpu_err_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cpu_req) state_d = req_mapped ? ACCESS : DONE;
      ACCESS:  if (sel_ack || timed_out) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    slv_sel_d   = slv_sel_q;
    slv_we_d    = slv_we_q;
    slv_addr_d  = slv_addr_q;
    slv_wdata_d = slv_wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    cpu_err_d   = 1'b0;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          slv_addr_d  = cpu_addr;
          slv_we_d    = cpu_we;
          slv_wdata_d = cpu_wdata;
          cnt_d       = '0;
          if (req_mapped) begin
            slv_sel_d = NSLV'(1) << req_idx;
          end else begin
            cpu_ready_d = 1'b1;
            cpu_err_d   = 1'b1;
            cpu_rdata_d = ERR_DATA;
            err_count_d = err_count_inc;
            err_addr_d  = cpu_addr;
          end
        end
      end
      ACCESS: begin
        if (sel_ack) begin
          slv_sel_d   = '0;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = sel_rdata;
        end else if (timed_out) begin
          slv_sel_d   = '0;
          cpu_ready_d = 1'b1;
          cpu_err_d   = 1'b1;
          cpu_rdata_d = ERR_DATA;
          err_count_d = err_count_inc;
          err_addr_d  = slv_addr_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_err   = cpu_err_q;
  assign slv_sel   = slv_sel_q;
  assign slv_we    = slv_we_q & (|slv_sel_q);
  assign slv_addr  = slv_addr_q;
  assign slv_wdata = slv_wdata_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_bus_handshake_ctrl.sv
// Bench for bus_handshake_ctrl: a 16-slave and a 12-slave instance share the bus
// inputs; expected latency, data and error bookkeeping come from a transaction model.
module tb_bus_handshake_ctrl;

  localparam int          TIMEOUT  = 15;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic         clk;
  logic         rst_n;
  logic         req_a, req_b;
  logic         cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [511:0] slv_rdata;
  logic [15:0]  slv_ack;

  logic [31:0] a_rdata, a_addr, a_wdata, a_err_addr;
  logic        a_ready, a_err, a_we;
  logic [15:0] a_sel;
  logic [7:0]  a_err_count;
  logic [31:0] b_rdata, b_addr, b_wdata, b_err_addr;
  logic        b_ready, b_err, b_we;
  logic [11:0] b_sel;
  logic [7:0]  b_err_count;

  bus_handshake_ctrl #(.NSLV(16), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(req_a), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(a_rdata), .cpu_ready(a_ready), .cpu_err(a_err),
    .slv_sel(a_sel), .slv_we(a_we), .slv_addr(a_addr), .slv_wdata(a_wdata),
    .slv_rdata(slv_rdata), .slv_ack(slv_ack), .err_count(a_err_count), .err_addr(a_err_addr)
  );

  bus_handshake_ctrl #(.NSLV(12), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut12 (
    .clk(clk), .rst_n(rst_n), .cpu_req(req_b), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(b_rdata), .cpu_ready(b_ready), .cpu_err(b_err),
    .slv_sel(b_sel), .slv_we(b_we), .slv_addr(b_addr), .slv_wdata(b_wdata),
    .slv_rdata(slv_rdata[383:0]), .slv_ack(slv_ack[11:0]), .err_count(b_err_count),
    .err_addr(b_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation mux: which instance the current transaction targets.
  logic        sel_b;
  wire [31:0] o_rdata     = sel_b ? b_rdata : a_rdata;
  wire        o_ready     = sel_b ? b_ready : a_ready;
  wire        o_err       = sel_b ? b_err : a_err;
  wire [15:0] o_sel       = sel_b ? {4'b0, b_sel} : a_sel;
  wire        o_we        = sel_b ? b_we : a_we;
  wire [31:0] o_addr      = sel_b ? b_addr : a_addr;
  wire [31:0] o_wdata     = sel_b ? b_wdata : a_wdata;
  wire [7:0]  o_err_count = sel_b ? b_err_count : a_err_count;
  wire [31:0] o_err_addr  = sel_b ? b_err_addr : a_err_addr;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Transaction-level model state, index 0 = 16-slave instance, 1 = 12-slave instance.
  int          m_err_cnt [2];
  logic [31:0] m_err_addr[2];
  logic [31:0] m_rdata   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_err_cnt[i]  = 0;
      m_err_addr[i] = '0;
      m_rdata[i]    = '0;
    end
  endtask

  task automatic model_error(input int b, input logic [31:0] addr);
    m_rdata[b]    = ERR_DATA;
    m_err_addr[b] = addr;
    if (m_err_cnt[b] < 255) m_err_cnt[b]++;
  endtask

  task automatic fill_rdata(input int k, input logic [31:0] rd);
    for (int i = 0; i < 16; i++) slv_rdata[32*i +: 32] = $urandom;
    slv_rdata[32*k +: 32] = rd;
  endtask

  // One complete transaction, entered and left on a falling edge. ack_wait is the number of
  // wait states before the slave acks (0 = ack in the first ACCESS cycle), negative = never.
  task automatic run_access(input int b, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_wait,
                            input logic [31:0] rd, input string tag);
    int          k      = int'(addr[31:28]);
    int          nslv   = (b != 0) ? 12 : 16;
    bit          mapped = k < nslv;
    bit          acked  = mapped && ack_wait >= 0 && ack_wait <= TIMEOUT;
    int          lat    = !mapped ? 1 : (acked ? ack_wait + 2 : TIMEOUT + 2);
    logic [15:0] onehot = 16'(1) << k;
    sel_b     = (b != 0);
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    if (b != 0) req_b = 1'b1; else req_a = 1'b1;
    fill_rdata(k, rd);
    if (acked) m_rdata[b] = rd;
    else       model_error(b, addr);
    for (int c = 1; c <= lat; c++) begin
      bit in_access;
      @(negedge clk);
      req_a     = 1'b0;
      req_b     = 1'b0;
      in_access = c < lat;
      check({tag, "/sel"}, 32'(o_sel), in_access ? 32'(onehot) : 32'd0);
      check({tag, "/slv_we"}, 32'(o_we), in_access ? 32'(we) : 32'd0);
      check({tag, "/ready"}, 32'(o_ready), (c == lat) ? 32'd1 : 32'd0);
      if (c == 1) begin
        check({tag, "/slv_addr"}, o_addr, addr);
        check({tag, "/slv_wdata"}, o_wdata, wdata);
      end
      if (c == lat) begin
        check({tag, "/err"}, 32'(o_err), acked ? 32'd0 : 32'd1);
        check({tag, "/rdata"}, o_rdata, m_rdata[b]);
        check({tag, "/err_count"}, 32'(o_err_count), 32'(m_err_cnt[b]));
        check({tag, "/err_addr"}, o_err_addr, m_err_addr[b]);
      end
      fill_rdata(k, rd);
      slv_ack = 16'($urandom) & ~onehot;
      if (acked && c == ack_wait + 1) slv_ack[k] = 1'b1;
    end
    slv_ack = '0;
    @(negedge clk);
    check({tag, "/ready_drop"}, 32'(o_ready), 32'd0);
    check({tag, "/rdata_hold"}, o_rdata, m_rdata[b]);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_a     = 1'b0;
    req_b     = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    slv_ack   = '0;
    sel_b     = 1'b0;
    fill_rdata(0, 32'h0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/ready", 32'(a_ready), 32'd0);
    check("rst/err", 32'(a_err), 32'd0);
    check("rst/rdata", a_rdata, 32'd0);
    check("rst/sel", 32'(a_sel), 32'd0);
    check("rst/slv_we", 32'(a_we), 32'd0);
    check("rst/slv_addr", a_addr, 32'd0);
    check("rst/slv_wdata", a_wdata, 32'd0);
    check("rst/err_count", 32'(a_err_count), 32'd0);
    check("rst/err_addr", a_err_addr, 32'd0);

    run_access(0, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678, "rd_s0");
    run_access(0, 1'b1, 32'hF000_0004, 32'h0000_00AB, 3, 32'h0BAD_F00D, "wr_s15");
    run_access(1, 1'b0, 32'hC000_0000, 32'h0, 0, 32'h1111_1111, "unmapped");
    run_access(0, 1'b0, 32'h2000_0000, 32'h0, -1, 32'h2222_2222, "timeout");
    run_access(0, 1'b0, 32'h2000_0008, 32'h0, TIMEOUT, 32'h3333_3333, "ack_last");

    // Reset in the middle of an access to slave 3.
    sel_b     = 1'b0;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h3000_0000;
    cpu_wdata = 32'h0000_0055;
    req_a     = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    check("midrst/sel_before", 32'(a_sel), 32'h8);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst/sel", 32'(a_sel), 32'd0);
    check("midrst/ready", 32'(a_ready), 32'd0);
    check("midrst/err", 32'(a_err), 32'd0);
    check("midrst/rdata", a_rdata, 32'd0);
    check("midrst/slv_we", 32'(a_we), 32'd0);
    check("midrst/slv_addr", a_addr, 32'd0);
    check("midrst/slv_wdata", a_wdata, 32'd0);
    check("midrst/err_count", 32'(a_err_count), 32'd0);
    check("midrst/err_addr", a_err_addr, 32'd0);
    check("midrst/err_count12", 32'(b_err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst/no_ready", 32'(a_ready), 32'd0);
    end
    run_access(0, 1'b0, 32'h3000_0040, 32'h0, 1, 32'hCAFE_0003, "after_rst");

    // Request held through DONE and the following IDLE cycle: accepted exactly once.
    sel_b     = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'hD000_0000;
    req_b     = 1'b1;
    model_error(1, 32'hD000_0000);
    @(negedge clk);
    check("hold/ready1", 32'(b_ready), 32'd1);
    cpu_addr = 32'hE000_0010;
    @(negedge clk);
    check("hold/idle", 32'(b_ready), 32'd0);
    model_error(1, 32'hE000_0010);
    @(negedge clk);
    req_b = 1'b0;
    check("hold/ready2", 32'(b_ready), 32'd1);
    check("hold/err_addr", b_err_addr, m_err_addr[1]);
    @(negedge clk);
    check("hold/idle2", 32'(b_ready), 32'd0);
    @(negedge clk);
    check("hold/no_repeat", 32'(b_ready), 32'd0);
    check("hold/err_count", 32'(b_err_count), 32'(m_err_cnt[1]));

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a = $urandom;
      a[31:28] = 4'(12 + $urandom_range(0, 3));
      run_access(1, 1'($urandom), a, $urandom, 0, $urandom, "sat");
    end
    check("sat/err_count_255", 32'(b_err_count), 32'd255);

    for (int i = 0; i < 60; i++) begin
      int bi = (i < 40) ? 1 : 0;
      int w  = int'($urandom_range(0, 18)) - 1;
      run_access(bi, 1'($urandom), $urandom, $urandom, w, $urandom, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_handshake_ctrl.md
# bus_handshake_ctrl

Parametrised, registered CPU-to-peripheral bus controller that replaces purely combinational address decoding with a request/ack handshake. It decodes the CPU address into one of NSLV slave channels, drives the selected slave until it acknowledges, and returns registered read data and a one-cycle ready pulse to the CPU. It adds variable wait-state support, unmapped-region and timeout error responses, and error bookkeeping. It sits between the MIPS core's memory port and RAM, VRAM, keyboard, move and random-number peripherals.

## Interface
- NSLV, 16: number of slave channels, 1..16; slave k owns region cpu_addr[31:28] == k.
- TIMEOUT, 15: maximum ACCESS cycles without ack before an error completion, at least 1.
- ERR_DATA, 32'hDEAD_BEEF: cpu_rdata value returned on any error completion.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request, sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  registered read data, valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  error flag, valid with cpu_ready.
- slv_sel  out  NSLV  one-hot slave select.
- slv_we  out  1  latched write enable, gated by any slv_sel bit.
- slv_addr  out  32  latched address.
- slv_wdata  out  32  latched write data.
- slv_rdata  in  32*NSLV  flattened read data; slave k uses bits [32k+31:32k].
- slv_ack  in  NSLV  per-slave acknowledge.
- err_count  out  8  saturating count of error completions.
- err_addr  out  32  address of the most recent error completion.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, cpu_req = 1:
  - Latch cpu_addr, cpu_we and cpu_wdata into slv_addr, slv_we and slv_wdata.
  - Compute k = cpu_addr[31:28].
  - If k < NSLV: go to ACCESS with slv_sel = 1 << k and clear the timeout counter.
  - If k >= NSLV (unmapped): go directly to DONE with error.
- ACCESS:
  - slv_sel, slv_addr, slv_we and slv_wdata are held stable.
  - Slaves commit a write on their ack cycle.
  - slv_ack[k] = 1: capture slv_rdata word k into cpu_rdata, with err = 0, and go to DONE.
  - No ack: increment the counter. When it reaches TIMEOUT with no ack, go to DONE with error.
  - Ack and timeout in the same cycle: ack wins, no error.
  - Acks on non-selected channels are ignored.
- DONE:
  - cpu_ready = 1 for exactly one cycle.
  - cpu_err shows the error status.
  - slv_sel = 0.
  - Next state is always IDLE.
- Error completion:
  - cpu_rdata = ERR_DATA and cpu_err = 1.
  - err_count increments, saturating at 255.
  - err_addr is loaded with the latched address.
  - Writes to an unmapped region or a timed-out slave are dropped.
- cpu_req outside IDLE is ignored. A request asserted in the DONE cycle is first sampled in the following IDLE cycle.
- Reset, asynchronous, any state, including mid-ACCESS:
  - State IDLE; slv_sel = 0, slv_we = 0, slv_addr = 0, slv_wdata = 0.
  - cpu_ready = 0, cpu_err = 0, cpu_rdata = 0.
  - err_count = 0, err_addr = 0, timeout counter = 0.
  - An in-flight access is abandoned without a completion pulse.
- cpu_rdata holds its value after DONE until the next completion.

## Timing
- Request sampled at edge n. slv_sel is high from n+1.
- Ack in cycle n+1 gives cpu_ready in cycle n+2. This is the minimum latency of 2 cycles.
- Each extra wait state adds 1 cycle.
- Timeout completion: cpu_ready in cycle n+TIMEOUT+2.
- Unmapped completion: cpu_ready in cycle n+1.
- Back-to-back throughput: at most one access per 3 cycles (IDLE, ACCESS, DONE).
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Read from slave 0 (addr 0x0000_0010) with slave 0 acking combinationally and data 0x1234_5678: cpu_ready at n+2, cpu_rdata = 0x1234_5678, cpu_err = 0.
- Write to slave 15 (addr 0xF000_0004, wdata 0xAB) with ack after 3 wait states: slv_sel = 0x8000 for 4 cycles, slv_we = 1, ready at n+5, err_count unchanged.
- Read from 0xC000_0000 with NSLV = 12: ready at n+1, cpu_rdata = 0xDEAD_BEEF, cpu_err = 1, err_count = 1, err_addr = 0xC000_0000.
- Slave 2 never acks, TIMEOUT = 15: ready at n+17 with cpu_err = 1. Separately, an ack arriving in the final counted cycle completes with cpu_err = 0.
- rst_n pulsed low mid-ACCESS: all outputs go to zero immediately, no cpu_ready pulse, and the next request completes normally.
- 300 unmapped requests: err_count saturates at 255, and a request held during DONE is accepted exactly once.
